// File: rtl/input_debounce_n.sv
// input_debounce_n: synchronise, debounce and edge-detect board pushbuttons
// and slide switches behind a shared millisecond tick prescaler.
//
// Optional feature macro: INPUT_DEBOUNCE_AUTOREPEAT_EN
//   When defined, adds REPEAT_DELAY_MS / REPEAT_RATE_MS and per-button
//   auto-repeat press pulses while a button is held away from idle.
//
// Ports:
//   clk          in   system clock
//   sysreset_n   in   asynchronous active-low reset
//   pbtn_in      in   raw button pins            [NUM_BTNS]
//   switch_in    in   raw switch pins            [NUM_SWS] (1 bit if NUM_SWS=0)
//   pbtn_db      out  debounced button levels    [NUM_BTNS]
//   swtch_db     out  debounced switch levels    [NUM_SWS]
//   pbtn_press   out  1-cycle pulse leaving idle [NUM_BTNS]
//   pbtn_release out  1-cycle pulse back to idle [NUM_BTNS]
//   tick         out  1-cycle prescaler strobe
module input_debounce_n #(
    parameter int                  NUM_BTNS    = 6,
    parameter int                  NUM_SWS     = 16,
    parameter int                  CLK_FREQ_HZ = 100000000,
    parameter int                  DEBOUNCE_MS = 5,
    parameter logic [NUM_BTNS-1:0] BTN_IDLE    = NUM_BTNS'(6'b000001),
    parameter int                  SIMULATE    = 0
`ifdef INPUT_DEBOUNCE_AUTOREPEAT_EN
    ,
    parameter int                  REPEAT_DELAY_MS = 500,
    parameter int                  REPEAT_RATE_MS  = 100
`endif
) (
    input  logic                                   clk,
    input  logic                                   sysreset_n,
    input  logic [NUM_BTNS-1:0]                    pbtn_in,
    input  logic [((NUM_SWS > 0) ? NUM_SWS : 1)-1:0] switch_in,
    output logic [NUM_BTNS-1:0]                    pbtn_db,
    output logic [((NUM_SWS > 0) ? NUM_SWS : 1)-1:0] swtch_db,
    output logic [NUM_BTNS-1:0]                    pbtn_press,
    output logic [NUM_BTNS-1:0]                    pbtn_release,
    output logic                                   tick
);

    localparam int TICK_DIV = (SIMULATE != 0) ? 4 : CLK_FREQ_HZ / 1000;
    localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW       = $clog2(DEBOUNCE_MS + 1);
    localparam int NCH      = NUM_BTNS + NUM_SWS;

    localparam logic [TW-1:0]  DIV_LAST = TW'(TICK_DIV - 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_MS - 1);
    // Buttons occupy the low channel bits, switches reset to 0 above them.
    localparam logic [NCH-1:0] RST_VAL  = NCH'(BTN_IDLE);

    // ---------------- prescaler ----------------
    logic [TW-1:0] div_q;
    logic [TW-1:0] div_d;
    logic          tick_w;

    assign tick_w = (div_q == DIV_LAST);
    assign div_d  = tick_w ? '0 : div_q + TW'(1);
    assign tick   = tick_w;

    // ---------------- channels ----------------
    logic [NCH-1:0] raw_w;
    logic [NCH-1:0] s1_q;
    logic [NCH-1:0] s2_q;
    logic [NCH-1:0] db_q;
    logic [NCH-1:0] db_d;
    logic [CW-1:0]  cnt_q [NCH];
    logic [CW-1:0]  cnt_d [NCH];

    generate
        if (NUM_SWS > 0) begin : g_sw
            assign raw_w    = {switch_in, pbtn_in};
            assign swtch_db = db_q[NCH-1:NUM_BTNS];
        end else begin : g_nosw
            logic unused_sw;
            assign unused_sw = ^switch_in;
            assign raw_w     = pbtn_in;
            assign swtch_db  = '0;
        end
    endgenerate

    assign pbtn_db = db_q[NUM_BTNS-1:0];

    // Any matching cycle restarts the count, so a glitch costs a full
    // debounce period; the flip happens on the DEBOUNCE_MS-th tick.
    always_comb begin
        db_d  = db_q;
        cnt_d = cnt_q;
        for (int i = 0; i < NCH; i++) begin
            if (s2_q[i] == db_q[i]) begin
                cnt_d[i] = '0;
            end else if (tick_w) begin
                if (cnt_q[i] == CNT_LAST) begin
                    db_d[i]  = s2_q[i];
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    // ---------------- edge pulses ----------------
    logic [NUM_BTNS-1:0] flip_w;
    logic [NUM_BTNS-1:0] press_d;
    logic [NUM_BTNS-1:0] release_d;
    logic [NUM_BTNS-1:0] press_q;
    logic [NUM_BTNS-1:0] release_q;

    assign flip_w    = db_d[NUM_BTNS-1:0] ^ db_q[NUM_BTNS-1:0];
    assign release_d = flip_w & ~(db_d[NUM_BTNS-1:0] ^ BTN_IDLE);

`ifdef INPUT_DEBOUNCE_AUTOREPEAT_EN
    // Down-counter of ticks until the next repeat; 0 means disarmed.
    logic [15:0]         rep_q [NUM_BTNS];
    logic [15:0]         rep_d [NUM_BTNS];
    logic [NUM_BTNS-1:0] rep_fire;

    always_comb begin
        rep_d    = rep_q;
        rep_fire = '0;
        for (int i = 0; i < NUM_BTNS; i++) begin
            if (flip_w[i]) begin
                rep_d[i] = release_d[i] ? '0 : 16'(REPEAT_DELAY_MS);
            end else if (db_q[i] == BTN_IDLE[i]) begin
                rep_d[i] = '0;
            end else if (tick_w && (rep_q[i] != '0)) begin
                if (rep_q[i] == 16'd1) begin
                    rep_fire[i] = 1'b1;
                    rep_d[i]    = 16'(REPEAT_RATE_MS);
                end else begin
                    rep_d[i] = rep_q[i] - 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge sysreset_n) begin
        if (!sysreset_n) begin
            for (int i = 0; i < NUM_BTNS; i++) begin
                rep_q[i] <= '0;
            end
        end else begin
            rep_q <= rep_d;
        end
    end

    assign press_d = (flip_w & ~release_d) | rep_fire;
`else
    assign press_d = flip_w & ~release_d;
`endif

    assign pbtn_press   = press_q;
    assign pbtn_release = release_q;

    // ---------------- state ----------------
    always_ff @(posedge clk or negedge sysreset_n) begin
        if (!sysreset_n) begin
            div_q     <= '0;
            s1_q      <= RST_VAL;
            s2_q      <= RST_VAL;
            db_q      <= RST_VAL;
            press_q   <= '0;
            release_q <= '0;
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            div_q     <= div_d;
            s1_q      <= raw_w;
            s2_q      <= s1_q;
            db_q      <= db_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

endmodule

// File: tb/tb_input_debounce_n.sv
// tb_input_debounce_n: self-checking bench for input_debounce_n with
// SIMULATE=1 (tick every 4 clocks) and DEBOUNCE_MS=5.
module tb_input_debounce_n;

    localparam int NB   = 6;
    localparam int NS   = 16;
    localparam int NCH  = NB + NS;
    localparam int DMS  = 5;
    localparam int TDIV = 4;
    localparam int NRND = 3000;
    localparam logic [NB-1:0]  IDLE    = 6'b000001;
    localparam logic [NCH-1:0] RSTV    = NCH'(IDLE);
    localparam logic [34:0]    RST_OUT = {IDLE, 16'h0, 6'h0, 6'h0, 1'b0};

    logic          clk = 1'b0;
    logic          sysreset_n;
    logic [NB-1:0] pbtn_in;
    logic [NS-1:0] switch_in;
    logic [NB-1:0] pbtn_db;
    logic [NS-1:0] swtch_db;
    logic [NB-1:0] pbtn_press;
    logic [NB-1:0] pbtn_release;
    logic          tick;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    input_debounce_n #(
        .NUM_BTNS   (NB),
        .NUM_SWS    (NS),
        .DEBOUNCE_MS(DMS),
        .BTN_IDLE   (IDLE),
        .SIMULATE   (1)
`ifdef INPUT_DEBOUNCE_AUTOREPEAT_EN
        ,
        .REPEAT_DELAY_MS(3),
        .REPEAT_RATE_MS (2)
`endif
    ) dut (
        .clk         (clk),
        .sysreset_n  (sysreset_n),
        .pbtn_in     (pbtn_in),
        .switch_in   (switch_in),
        .pbtn_db     (pbtn_db),
        .swtch_db    (swtch_db),
        .pbtn_press  (pbtn_press),
        .pbtn_release(pbtn_release),
        .tick        (tick)
    );

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [34:0] outs();
        return {pbtn_db, swtch_db, pbtn_press, pbtn_release, tick};
    endfunction

    // Number of tick cycles (t % TDIV == TDIV-1) in [a, b].
    function automatic int ticks_in(input int a, input int b);
        return (b + 1) / TDIV - a / TDIV;
    endfunction

    typedef struct {
        logic [NB-1:0] btn;
        logic [NS-1:0] sw;
        logic [34:0]   exp;
    } vec_t;

    vec_t tbl[6];

    logic [NCH-1:0] hist [NRND];
    logic [NCH-1:0] mdb, nxt, sync, pins;
    logic [NB-1:0]  mp, mr, np, nr;
    int             mstart [NCH];

    initial begin
        int n, ticks_seen;
        bit found, bad_db, bad_pl;
        logic [NB-1:0] pr, rl;
        logic [NS-1:0] prev_sw, sw_at;
        logic [34:0] act, exp;

        sysreset_n = 1'b0;
        pbtn_in    = IDLE;
        switch_in  = '0;

        // ---- reset state under random pins (table driven) ----
        for (int i = 0; i < 6; i++) begin
            tbl[i].btn = NB'($urandom);
            tbl[i].sw  = NS'($urandom);
            tbl[i].exp = RST_OUT;
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            pbtn_in   = tbl[i].btn;
            switch_in = tbl[i].sw;
            @(negedge clk);
            check($sformatf("reset_vec%0d", i), outs(), tbl[i].exp);
        end

        // ---- reset release with idle pins ----
        pbtn_in   = IDLE;
        switch_in = '0;
        @(negedge clk);
        sysreset_n = 1'b1;
        bad_db = 0; bad_pl = 0; ticks_seen = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (pbtn_db != IDLE || swtch_db != '0) bad_db = 1;
            if (pbtn_press != '0 || pbtn_release != '0) bad_pl = 1;
            if (tick) ticks_seen++;
        end
        check("idle_db_stable", bad_db, 0);
        check("idle_no_pulse", bad_pl, 0);
        check("tick_count_100", ticks_seen, 25);

        // ---- clean press on button 1 ----
        pbtn_in[1] = 1'b1;
        found = 0; n = 0; pr = '0; rl = '0;
        for (int k = 1; k <= 40 && !found; k++) begin
            @(negedge clk);
            if (pbtn_db[1]) begin
                found = 1; n = k; pr = pbtn_press; rl = pbtn_release;
            end
        end
        check("press_latency", (found && n >= 19 && n <= 22), 1);
        check("press_pulse", {pr, rl}, {6'b000010, 6'b000000});
        @(negedge clk);
        check("press_one_cycle", pbtn_press, 6'b0);

        pbtn_in[1] = 1'b0;
        found = 0; n = 0; pr = '0; rl = '0;
        for (int k = 1; k <= 40 && !found; k++) begin
            @(negedge clk);
            if (!pbtn_db[1]) begin
                found = 1; n = k; pr = pbtn_press; rl = pbtn_release;
            end
        end
        check("release_latency", (found && n >= 19 && n <= 22), 1);
        check("release_pulse", {pr, rl}, {6'b000000, 6'b000010});
        @(negedge clk);
        check("release_one_cycle", pbtn_release, 6'b0);

        // ---- glitch rejection on button 2 ----
        bad_db = 0; bad_pl = 0;
        pbtn_in[2] = 1'b1;
        for (int k = 0; k < 96; k++) begin
            @(negedge clk);
            if (k == 0)  pbtn_in[2] = 1'b0;
            if (k == 10) pbtn_in[2] = 1'b1;
            if (k == 25) pbtn_in[2] = 1'b0;
            if (pbtn_db[2]) bad_db = 1;
            if (pbtn_press != '0 || pbtn_release != '0) bad_pl = 1;
        end
        check("glitch_db", bad_db, 0);
        check("glitch_no_pulse", bad_pl, 0);

        // ---- active-low button 0 ----
        pbtn_in[0] = 1'b0;
        found = 0; pr = '0; rl = '0;
        for (int k = 1; k <= 40 && !found; k++) begin
            @(negedge clk);
            if (!pbtn_db[0]) begin
                found = 1; pr = pbtn_press; rl = pbtn_release;
            end
        end
        check("al_press_seen", found, 1);
        check("al_press_pulse", {pr, rl}, {6'b000001, 6'b000000});
        @(negedge clk);
        check("al_press_one_cycle", {pbtn_press, pbtn_release}, 12'h0);
        pbtn_in[0] = 1'b1;
        found = 0; pr = '0; rl = '0;
        for (int k = 1; k <= 40 && !found; k++) begin
            @(negedge clk);
            if (pbtn_db[0]) begin
                found = 1; pr = pbtn_press; rl = pbtn_release;
            end
        end
        check("al_release_seen", found, 1);
        check("al_release_pulse", {pr, rl}, {6'b000000, 6'b000001});
        @(negedge clk);
        check("al_release_one_cycle", {pbtn_press, pbtn_release}, 12'h0);

        // ---- simultaneous switches and button 4, then reset mid-count ----
        switch_in  = 16'hA5C3;
        pbtn_in[4] = 1'b1;
        found = 0; prev_sw = swtch_db; sw_at = '0; pr = '0;
        for (int k = 1; k <= 40 && !found; k++) begin
            @(negedge clk);
            if (pbtn_db[4]) begin
                found = 1; sw_at = swtch_db; pr = pbtn_press;
            end else begin
                prev_sw = swtch_db;
            end
        end
        check("simul_seen", found, 1);
        check("simul_sw_same_edge", {prev_sw, sw_at}, {16'h0, 16'hA5C3});
        check("simul_press4", pr, 6'b010000);
        switch_in  = '0;
        pbtn_in[4] = 1'b0;
        repeat (8) @(negedge clk);
        #2;
        sysreset_n = 1'b0;
        #1;
        check("async_reset_now", outs(), RST_OUT);
        @(negedge clk);
        check("reset_held", outs(), RST_OUT);
        @(negedge clk);
        sysreset_n = 1'b1;
        bad_db = 0; bad_pl = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (pbtn_db != IDLE || swtch_db != '0) bad_db = 1;
            if (pbtn_press != '0 || pbtn_release != '0) bad_pl = 1;
        end
        check("post_reset_db", bad_db, 0);
        check("post_reset_no_pulse", bad_pl, 0);

`ifdef INPUT_DEBOUNCE_AUTOREPEAT_EN
        // ---- auto-repeat on button 3 ----
        begin
            logic [63:0] mask;
            pbtn_in[3] = 1'b1;
            found = 0;
            for (int k = 1; k <= 40 && !found; k++) begin
                @(negedge clk);
                if (pbtn_press[3]) found = 1;
            end
            check("rep_first_press", found, 1);
            mask = '0;
            for (int k = 1; k <= 40; k++) begin
                @(negedge clk);
                if (pbtn_press[3]) mask[k] = 1'b1;
            end
            check("rep_schedule", mask,
                  (64'd1 << 12) | (64'd1 << 20) | (64'd1 << 28) | (64'd1 << 36));
            pbtn_in[3] = 1'b0;
            found = 0;
            for (int k = 1; k <= 40 && !found; k++) begin
                @(negedge clk);
                if (pbtn_release[3]) found = 1;
            end
            check("rep_release", found, 1);
            bad_pl = 0;
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                if (pbtn_press != '0) bad_pl = 1;
            end
            check("rep_stopped", bad_pl, 0);
        end
`endif

        // ---- randomized run against reference model ----
        sysreset_n = 1'b0;
        pbtn_in    = IDLE;
        switch_in  = '0;
        @(negedge clk);
        @(negedge clk);
        sysreset_n = 1'b1;
        mdb  = RSTV;
        mp   = '0;
        mr   = '0;
        pins = RSTV;
        for (int i = 0; i < NCH; i++) mstart[i] = -1;
        for (int c = 0; c < NRND; c++) begin
            if (c > 0) @(negedge clk);
            act = outs();
            exp = {mdb[NB-1:0], mdb[NCH-1:NB], mp, mr, (c % TDIV == TDIV - 1)};
`ifdef INPUT_DEBOUNCE_AUTOREPEAT_EN
            act[12:7] = '0;
            exp[12:7] = '0;
`endif
            check($sformatf("rand_c%0d", c), act, exp);

            for (int i = 0; i < NCH; i++) begin
                if ($urandom_range(0, 29) == 0) pins[i] = ~pins[i];
            end
            pbtn_in   = pins[NB-1:0];
            switch_in = pins[NCH-1:NB];
            hist[c]   = pins;

            // The debounce logic sees each pin two cycles late; a channel
            // flips on the DMS-th tick of an unbroken mismatch run.
            sync = (c < 2) ? RSTV : hist[c-2];
            nxt = mdb; np = '0; nr = '0;
            for (int i = 0; i < NCH; i++) begin
                if (sync[i] != mdb[i]) begin
                    if (mstart[i] < 0) mstart[i] = c;
                    if ((c % TDIV == TDIV - 1) && ticks_in(mstart[i], c) == DMS) begin
                        nxt[i] = sync[i];
                        mstart[i] = -1;
                        if (i < NB) begin
                            if (sync[i] != IDLE[i]) np[i] = 1'b1;
                            else                    nr[i] = 1'b1;
                        end
                    end
                end else begin
                    mstart[i] = -1;
                end
            end
            mdb = nxt; mp = np; mr = nr;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
